// File: rtl/chain_cost_engine.sv
// Matrix-chain cost engine: evaluates streamed (i,j,k) split beats through a
// 3-stage pipeline and keeps the minimum cost and split per (i,j) in a table.
module chain_cost_engine #(
  parameter int NMAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  matlen,
  input  logic        start,
  input  logic        dim_we,
  input  logic [3:0]  dim_addr,
  input  logic [7:0]  dim_data,
  input  logic        idx_valid,
  output logic        idx_ready,
  input  logic [7:0]  ir,
  input  logic [7:0]  jr,
  input  logic [7:0]  kr,
  input  logic        rw,
  input  logic [3:0]  rd_i,
  input  logic [3:0]  rd_j,
  output logic [31:0] rd_cost,
  output logic [7:0]  rd_split,
  output logic        busy,
  output logic        done,
  output logic        err
);
  // state | meaning
  // IDLE  | waiting for start after reset
  // RUN   | accepting index beats
  // DRAIN | final beat accepted, pipeline emptying
  // DONE  | table complete, waiting for start
  localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3;
  localparam int AW = $clog2(NMAX);
  localparam int PW = $clog2(NMAX + 1);

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [31:0] m_q [NMAX][NMAX];
  logic [31:0] m_d [NMAX][NMAX];
  logic [7:0]  s_q [NMAX][NMAX];
  logic [7:0]  s_d [NMAX][NMAX];
  logic [7:0]  p_q [NMAX+1];
  logic [7:0]  p_d [NMAX+1];

  logic [1:0]  state_q, state_d, hold_q, hold_d;
  logic [7:0]  n_q, n_d;
  logic        err_q, err_d, first_q, first_d;

  logic          s1_v_q, s1_v_d, s1_rw_q, s1_rw_d, s1_first_q, s1_first_d;
  logic [AW-1:0] s1_i_q, s1_i_d, s1_j_q, s1_j_d, s1_k_q, s1_k_d;
  logic [31:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [7:0]    s1_pi_q, s1_pi_d, s1_pk_q, s1_pk_d, s1_pj_q, s1_pj_d;

  logic          s2_v_q, s2_v_d, s2_rw_q, s2_rw_d, s2_first_q, s2_first_d;
  logic [AW-1:0] s2_i_q, s2_i_d, s2_j_q, s2_j_d, s2_k_q, s2_k_d;
  logic [31:0]   s2_msum_q, s2_msum_d;
  logic [23:0]   s2_prod_q, s2_prod_d;

  logic [31:0]   min_q, min_d;
  logic [AW-1:0] mink_q, mink_d, wb_i_q, wb_i_d, wb_j_q, wb_j_d;
  logic          wb_v_q, wb_v_d;

  logic          acc, beat_ok, last;
  logic [AW-1:0] k1_idx;
  logic [PW-1:0] pi_idx, pk_idx, pj_idx;
  logic [31:0]   cost;

  assign idx_ready = (state_q == ST_RUN) && (hold_q == 2'd0);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;

  assign acc     = idx_valid && idx_ready;
  assign beat_ok = (ir <= kr) && (kr < jr) && (jr < n_q) && (jr < 8'(NMAX));
  assign last    = rw && (ir == 8'd0) && (jr == n_q - 8'd1);
  assign k1_idx  = kr[AW-1:0] + AW'(1);
  assign pi_idx  = PW'(ir[AW-1:0]);
  assign pk_idx  = PW'(kr[AW-1:0]) + PW'(1);
  assign pj_idx  = PW'(jr[AW-1:0]) + PW'(1);
  assign cost    = sat_add(s2_msum_q, {8'd0, s2_prod_q});

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    err_d   = err_q;
    first_d = first_q;
    hold_d  = (hold_q != 2'd0) ? hold_q - 2'd1 : hold_q;
    m_d     = m_q;
    s_d     = s_q;
    p_d     = p_q;

    // S1: capture indices and operands every cycle; valid qualifies them
    s1_v_d     = 1'b0;
    s1_rw_d    = rw;
    s1_first_d = first_q;
    s1_i_d     = ir[AW-1:0];
    s1_j_d     = jr[AW-1:0];
    s1_k_d     = kr[AW-1:0];
    s1_a_d     = m_q[ir[AW-1:0]][kr[AW-1:0]];
    s1_b_d     = m_q[k1_idx][jr[AW-1:0]];
    s1_pi_d    = p_q[pi_idx];
    s1_pk_d    = p_q[pk_idx];
    s1_pj_d    = p_q[pj_idx];

    s2_v_d     = s1_v_q;
    s2_rw_d    = s1_rw_q;
    s2_first_d = s1_first_q;
    s2_i_d     = s1_i_q;
    s2_j_d     = s1_j_q;
    s2_k_d     = s1_k_q;
    s2_msum_d  = sat_add(s1_a_q, s1_b_q);
    s2_prod_d  = 24'(s1_pi_q) * 24'(s1_pk_q) * 24'(s1_pj_q);

    min_d  = min_q;
    mink_d = mink_q;
    wb_v_d = 1'b0;
    wb_i_d = s2_i_q;
    wb_j_d = s2_j_q;
    if (s2_v_q) begin
      if (s2_first_q || (cost < min_q)) begin
        min_d  = cost;
        mink_d = s2_k_q;
      end
      wb_v_d = s2_rw_q;
    end

    if (wb_v_q) begin
      m_d[wb_i_q][wb_j_q] = min_q;
      s_d[wb_i_q][wb_j_q] = 8'(mink_q);
    end

    if (dim_we && !busy && (int'(dim_addr) <= NMAX))
      p_d[dim_addr[PW-1:0]] = dim_data;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          for (int a = 0; a < NMAX; a++)
            for (int b = 0; b < NMAX; b++) begin
              m_d[a][b] = '0;
              s_d[a][b] = '0;
            end
          n_d     = matlen;
          err_d   = 1'b0;
          first_d = 1'b1;
          hold_d  = 2'd0;
          s1_v_d  = 1'b0;
          s2_v_d  = 1'b0;
          wb_v_d  = 1'b0;
          state_d = (matlen < 8'd2) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (acc) begin
          if (!beat_ok) begin
            err_d = 1'b1;
          end else begin
            s1_v_d  = 1'b1;
            first_d = rw;
            if (rw) hold_d = 2'd3;
            if (last) state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (hold_q == 2'd1) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      err_q      <= 1'b0;
      first_q    <= 1'b1;
      hold_q     <= '0;
      for (int a = 0; a < NMAX; a++)
        for (int b = 0; b < NMAX; b++) begin
          m_q[a][b] <= '0;
          s_q[a][b] <= '0;
        end
      for (int a = 0; a <= NMAX; a++) p_q[a] <= '0;
      s1_v_q     <= 1'b0;
      s1_rw_q    <= 1'b0;
      s1_first_q <= 1'b0;
      s1_i_q     <= '0;
      s1_j_q     <= '0;
      s1_k_q     <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_pi_q    <= '0;
      s1_pk_q    <= '0;
      s1_pj_q    <= '0;
      s2_v_q     <= 1'b0;
      s2_rw_q    <= 1'b0;
      s2_first_q <= 1'b0;
      s2_i_q     <= '0;
      s2_j_q     <= '0;
      s2_k_q     <= '0;
      s2_msum_q  <= '0;
      s2_prod_q  <= '0;
      min_q      <= '0;
      mink_q     <= '0;
      wb_v_q     <= 1'b0;
      wb_i_q     <= '0;
      wb_j_q     <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      err_q      <= err_d;
      first_q    <= first_d;
      hold_q     <= hold_d;
      m_q        <= m_d;
      s_q        <= s_d;
      p_q        <= p_d;
      s1_v_q     <= s1_v_d;
      s1_rw_q    <= s1_rw_d;
      s1_first_q <= s1_first_d;
      s1_i_q     <= s1_i_d;
      s1_j_q     <= s1_j_d;
      s1_k_q     <= s1_k_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_pi_q    <= s1_pi_d;
      s1_pk_q    <= s1_pk_d;
      s1_pj_q    <= s1_pj_d;
      s2_v_q     <= s2_v_d;
      s2_rw_q    <= s2_rw_d;
      s2_first_q <= s2_first_d;
      s2_i_q     <= s2_i_d;
      s2_j_q     <= s2_j_d;
      s2_k_q     <= s2_k_d;
      s2_msum_q  <= s2_msum_d;
      s2_prod_q  <= s2_prod_d;
      min_q      <= min_d;
      mink_q     <= mink_d;
      wb_v_q     <= wb_v_d;
      wb_i_q     <= wb_i_d;
      wb_j_q     <= wb_j_d;
    end
  end

  always_comb begin
    rd_cost  = '0;
    rd_split = '0;
    if ((int'(rd_i) < NMAX) && (int'(rd_j) < NMAX)) begin
      rd_cost  = m_q[rd_i[AW-1:0]][rd_j[AW-1:0]];
      rd_split = s_q[rd_i[AW-1:0]][rd_j[AW-1:0]];
    end
  end

endmodule

// File: doc/chain_cost_engine.md
CHAIN_COST_ENGINE -- requirements
Module: chain_cost_engine

Interface
REQ-001 SHALL have parameter NMAX, default 8, giving the maximum matrix count; table and dimension storage are sized from it.
REQ-002 SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port matlen, input, 8, the matrix count N; it is sampled on start.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a run.
REQ-006 SHALL have ports dim_we (input, 1), dim_addr (input, 4) and dim_data (input, 8), which write dimension p[dim_addr] for addresses 0..NMAX.
REQ-007 SHALL have ports idx_valid (input, 1) and idx_ready (output, 1), the index-beat handshake.
REQ-008 SHALL have ports ir, jr, kr (input, 8 each), the beat indices i, j, k.
REQ-009 SHALL have port rw, input, 1, which marks the beat as the last k for the current (i,j).
REQ-010 SHALL have ports rd_i and rd_j (input, 4 each), the combinational table readout address.
REQ-011 SHALL have ports rd_cost (output, 32) and rd_split (output, 8), giving m[rd_i][rd_j] and s[rd_i][rd_j].
REQ-012 SHALL have ports busy, done and err (output, 1 each).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
- IDLE -> RUN on start.
- RUN -> DRAIN when the beat with rw=1, ir=0, jr=N-1 is accepted.
- DRAIN -> DONE after the 3-cycle pipeline empties.
- DONE -> RUN on start.
REQ-014 SHALL, on start, clear every m entry to 0 and every s entry to 0 in that cycle, latch N, and clear err.
REQ-015 SHALL, on start with N<2, go directly to DONE on the next cycle with m[0][0]=0.
REQ-016 SHALL accept a beat only when idx_valid=1 and idx_ready=1; idx_ready is 1 only in RUN and outside a drain hold.
REQ-017 SHALL compute, per accepted beat, cost = m[i][k] + m[k+1][j] + p[i]*p[k+1]*p[j+1]. The product is 24 bits; sums are 32-bit saturating at 0xFFFFFFFF.
REQ-018 SHALL run a 3-stage pipeline:
- S1 registers indices and reads operands.
- S2 forms the product.
- S3 adds and updates the running minimum.
REQ-019 SHALL use the first k of each (i,j) group (the beat after an rw beat, or the first beat after start) to load the running minimum unconditionally.
REQ-020 SHALL replace the running minimum only on a strictly smaller cost, so the earliest k wins ties.
REQ-021 SHALL, when the rw beat reaches S3, write m[i][j] = final minimum and s[i][j] = its k, exactly 3 cycles after acceptance.
REQ-022 SHALL, after accepting an rw beat, hold idx_ready=0 until the corresponding write has completed, so later groups never read stale m.
REQ-023 SHALL drop, and not write, any beat with ir>kr, kr>=jr or jr>=N, and SHALL set sticky err; the running minimum is unaffected.
REQ-024 SHALL ignore dim_we while busy=1.
REQ-025 SHALL ignore start while in RUN or DRAIN.
REQ-026 SHALL drive busy=1 in RUN and DRAIN.
REQ-027 SHALL drive done=1 in DONE only.
REQ-028 SHALL keep rd_cost and rd_split combinational from rd_i and rd_j; out-of-range addresses read 0.

Reset
REQ-029 SHALL, while reset=0 at a clock edge, enter IDLE and clear m, s and p, with outputs idx_ready=0, busy=0, done=0, err=0, rd_cost=0 and rd_split=0.
REQ-030 SHALL abort any run on reset asserted mid-RUN or mid-DRAIN, with all in-flight beats discarded and no table write.

Verification
REQ-031 SHALL pass: p={10,20,30}, N=2, beat (0,1,k=0,rw=1) -> m[0][1]=6000, s=0, done 4 cycles after acceptance.
REQ-032 SHALL pass: p={10,30,5,60}, N=3, full beat stream -> m[0][1]=1500, m[1][2]=9000, m[0][2]=4500, s[0][2]=1.
REQ-033 SHALL pass: an rw beat accepted at cycle t -> idx_ready=0 during t+1..t+3, then 1.
REQ-034 SHALL pass: p all 255, N=8, full stream -> no wrap below true value; any overflowing cost reads 0xFFFFFFFF.
REQ-035 SHALL pass: beat ir=2, jr=1 -> err=1, table unchanged; a following valid stream still completes correctly.
REQ-036 SHALL pass: reset=0 two cycles after start -> busy=0, all m=0, and a new start runs clean.
